// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared types and constants for the programmable clock divider
package freq_div_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_core.sv
// rtl/freq_div_core.sv - period counter and 50%-duty clock shaping for a given ratio
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] ratio_i,
    input  logic             run_i,
    input  logic             load_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             clk_out_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] half;
    logic             pos_hi_q;
    logic             pos_hi_d;
    logic             neg_hi_q;

    assign half   = ratio_i >> 1;
    assign wrap_o = run_i && (cnt_q == ratio_i - WIDTH'(1));

    // pos_hi is registered from the next count so it lines up with cnt_q,
    // which makes clk_out rise on the very first cycle of each period.
    always_comb begin
        cnt_d = '0;
        if (load_i && run_i && !wrap_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        pos_hi_d = load_i && (cnt_d < half);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            pos_hi_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pos_hi_q <= pos_hi_d;
        end
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_hi_q <= 1'b0;
        end else begin
            neg_hi_q <= pos_hi_q;
        end
    end

    // Odd ratios stretch the high phase by half a clk cycle via the negedge copy.
    assign clk_out_o = pos_hi_q | (ratio_i[0] & neg_hi_q);
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - run/stop sequencer and ratio handshake around the divider core
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    output logic [WIDTH-1:0] div_active,
    output logic             running,
    output logic             tick,
    output logic             clk_out
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic             pend_valid_q;
    logic             pend_valid_d;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] active_d;
    logic             err_q;
    logic             err_d;
    logic             xfer;
    logic             wrap;
    logic [WIDTH-1:0] cnt;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        active_d     = active_q;
        err_d        = 1'b0;
        xfer         = div_valid && !pend_valid_q;

        case (state_q)
            STOP:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = wrap ? STOP : DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = STOP;
                end
            end
            default: state_d = STOP;
        endcase

        if (xfer) begin
            if (div_val < WIDTH'(MIN_DIV)) begin
                err_d = 1'b1;
            end else begin
                pend_d       = div_val;
                pend_valid_d = 1'b1;
            end
        end

        // A ratio only lands at a period boundary (or immediately when idle).
        if (pend_valid_q && (state_q == STOP || wrap)) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= STOP;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            active_q     <= WIDTH'(DEFAULT_DIV);
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            active_q     <= active_d;
            err_q        <= err_d;
        end
    end

    freq_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i     (clk),
        .rst_i     (reset),
        .ratio_i   (active_q),
        .run_i     (state_q != STOP),
        .load_i    (state_d != STOP),
        .cnt_o     (cnt),
        .wrap_o    (wrap),
        .clk_out_o (clk_out)
    );

    assign div_ready  = ~pend_valid_q;
    assign div_err    = err_q;
    assign div_active = active_q;
    assign running    = (state_q != STOP);
    assign tick       = (state_q != STOP) && (cnt == '0) && (state_d != STOP);

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb/tb_freq_div_ctrl.sv - directed self-checking bench for freq_div_ctrl
module tb_freq_div_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_valid;
    logic         div_ready;
    logic         div_err;
    logic [W-1:0] div_active;
    logic         running;
    logic         tick;
    logic         clk_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] halves;
    logic [15:0] ticks;

    always #5 clk = ~clk;

    freq_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_val    (div_val),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_err    (div_err),
        .div_active (div_active),
        .running    (running),
        .tick       (tick),
        .clk_out    (clk_out)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Records clk_out in both halves of n consecutive clk cycles, LSB first.
    task automatic sample_period(input int n, output logic [31:0] h, output logic [15:0] t);
        h = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            h[2*i] = clk_out;
            t[i]   = tick;
            @(negedge clk);
            #2;
            h[2*i+1] = clk_out;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; div_val = '0; div_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (div_err !== 1'b0) begin n_bad++; $display("FAIL reset_div_err: got %b want 0", div_err); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL reset_div_ready: got %b want 1", div_ready); end
        n_cmp++; if (div_active !== 8'd3) begin n_bad++; $display("FAIL reset_div_active: got %0d want 3", div_active); end
        reset = 1'b0;
    endtask

    task automatic test_default_run();
        en = 1'b1;
        step();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_start_running: got %b want 1", running); end
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL run_start_tick: got %b want 1", tick); end
        n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL run_start_clk_out: got %b want 1", clk_out); end
        for (int p = 0; p < 2; p++) begin
            sample_period(3, halves, ticks);
            n_cmp++; if (halves !== 32'h07) begin n_bad++; $display("FAIL n3_shape[%0d]: got %h want 07", p, halves); end
            n_cmp++; if (ticks !== 16'h1) begin n_bad++; $display("FAIL n3_ticks[%0d]: got %h want 1", p, ticks); end
        end
    endtask

    task automatic test_ratio_change();
        div_val = 8'd4; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_cmp++; if (div_ready !== 1'b0) begin n_bad++; $display("FAIL n4_ready_pending1: got %b want 0", div_ready); end
        step();
        n_cmp++; if (div_ready !== 1'b0) begin n_bad++; $display("FAIL n4_ready_pending2: got %b want 0", div_ready); end
        n_cmp++; if (div_active !== 8'd3) begin n_bad++; $display("FAIL n4_active_before_wrap: got %0d want 3", div_active); end
        step();
        n_cmp++; if (div_active !== 8'd4) begin n_bad++; $display("FAIL n4_active_after_wrap: got %0d want 4", div_active); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL n4_ready_after_wrap: got %b want 1", div_ready); end
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL n4_tick_after_wrap: got %b want 1", tick); end
        sample_period(4, halves, ticks);
        n_cmp++; if (halves !== 32'h0F) begin n_bad++; $display("FAIL n4_shape: got %h want 0f", halves); end
        n_cmp++; if (ticks !== 16'h1) begin n_bad++; $display("FAIL n4_ticks: got %h want 1", ticks); end
    endtask

    task automatic test_reject();
        div_val = 8'd1; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_cmp++; if (div_err !== 1'b1) begin n_bad++; $display("FAIL rej1_err: got %b want 1", div_err); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL rej1_ready: got %b want 1", div_ready); end
        step();
        n_cmp++; if (div_err !== 1'b0) begin n_bad++; $display("FAIL rej1_err_pulse: got %b want 0", div_err); end
        div_val = 8'd0; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_cmp++; if (div_err !== 1'b1) begin n_bad++; $display("FAIL rej0_err: got %b want 1", div_err); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL rej0_ready: got %b want 1", div_ready); end
        step();
        n_cmp++; if (div_err !== 1'b0) begin n_bad++; $display("FAIL rej0_err_pulse: got %b want 0", div_err); end
        n_cmp++; if (div_active !== 8'd4) begin n_bad++; $display("FAIL rej_active: got %0d want 4", div_active); end
        sample_period(4, halves, ticks);
        n_cmp++; if (halves !== 32'h0F) begin n_bad++; $display("FAIL rej_shape: got %h want 0f", halves); end
    endtask

    task automatic test_drain();
        div_val = 8'd5; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        repeat (3) step();
        n_cmp++; if (div_active !== 8'd5) begin n_bad++; $display("FAIL n5_active: got %0d want 5", div_active); end
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL drain_running[%0d]: got %b want 1", i, running); end
            n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL drain_tick[%0d]: got %b want 0", i, tick); end
        end
        step();
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running: got %b want 0", running); end
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL stop_clk_out: got %b want 0", clk_out); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stop_tick: got %b want 0", tick); end
        @(negedge clk);
        #2;
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL stop_clk_out_neg: got %b want 0", clk_out); end
        step();
        en = 1'b1;
        step();
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL restart_tick: got %b want 1", tick); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL restart_running: got %b want 1", running); end
        n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL restart_clk_out: got %b want 1", clk_out); end
    endtask

    task automatic test_wrap_transfer();
        repeat (4) step();
        div_val = 8'd2; div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        n_cmp++; if (div_active !== 8'd5) begin n_bad++; $display("FAIL wrapx_active_old: got %0d want 5", div_active); end
        n_cmp++; if (div_ready !== 1'b0) begin n_bad++; $display("FAIL wrapx_ready: got %b want 0", div_ready); end
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL wrapx_tick: got %b want 1", tick); end
        sample_period(5, halves, ticks);
        n_cmp++; if (halves !== 32'h1F) begin n_bad++; $display("FAIL n5_shape: got %h want 1f", halves); end
        n_cmp++; if (ticks !== 16'h1) begin n_bad++; $display("FAIL n5_ticks: got %h want 1", ticks); end
        n_cmp++; if (div_active !== 8'd2) begin n_bad++; $display("FAIL wrapx_active_new: got %0d want 2", div_active); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL wrapx_ready_back: got %b want 1", div_ready); end
        for (int p = 0; p < 2; p++) begin
            sample_period(2, halves, ticks);
            n_cmp++; if (halves !== 32'h3) begin n_bad++; $display("FAIL n2_shape[%0d]: got %h want 3", p, halves); end
            n_cmp++; if (ticks !== 16'h1) begin n_bad++; $display("FAIL n2_ticks[%0d]: got %h want 1", p, ticks); end
        end
    endtask

    task automatic test_async_reset();
        n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL areset_pre_hi: got %b want 1", clk_out); end
        @(negedge clk);
        #2;
        n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL areset_pre_hi_neg: got %b want 1", clk_out); end
        en = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL areset_clk_out: got %b want 0", clk_out); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL areset_running: got %b want 0", running); end
        step();
        reset = 1'b0;
        n_cmp++; if (div_active !== 8'd3) begin n_bad++; $display("FAIL areset_active: got %0d want 3", div_active); end
        n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %b want 1", div_ready); end
        step();
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL areset_stays_stop: got %b want 0", running); end
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL areset_clk_low: got %b want 0", clk_out); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_ratio_change();
        test_reject();
        test_drain();
        test_wrap_transfer();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
